// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates pdm_clk, captures the 1-bit stream and
// decimates it with a CIC_ORDER-stage CIC into signed DATA_WIDTH-bit PCM.
// Optional build macro PDM_CIC_SATURATE_EN clamps the scaled result instead of wrapping.
`timescale 1ns/1ps
module pdm_cic_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int CIC_ORDER  = 4,
  parameter int DECIMATION = 64,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  pdm_data,
  output logic                  pdm_clk,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  localparam int LOG2_DEC = $clog2(DECIMATION);
  localparam int W        = CIC_ORDER * LOG2_DEC + 2;
  localparam int S        = CIC_ORDER * LOG2_DEC - (DATA_WIDTH - 1);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Reject parameter sets the datapath cannot represent.
  if (S < 0) begin : g_chk_shift
    $error("pdm_cic_decimator: CIC growth smaller than DATA_WIDTH-1");
  end
  if ((DECIMATION < 2) || ((1 << LOG2_DEC) != DECIMATION)) begin : g_chk_dec
    $error("pdm_cic_decimator: DECIMATION must be a power of two >= 2");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("pdm_cic_decimator: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0]    div_cnt;
  logic [LOG2_DEC-1:0] dec_cnt;
  logic [1:0]          sync_q;
  logic                tick;
  logic                strobe;
  logic signed [W-1:0] x_map;
  logic signed [W-1:0] integ   [CIC_ORDER];
  logic signed [W-1:0] dly     [CIC_ORDER];
  logic signed [W-1:0] comb_in [CIC_ORDER];
  logic signed [W-1:0] comb_res;
  logic signed [W-1:0] scaled;
  logic [DATA_WIDTH-1:0] pcm;

  // Tick is the cycle whose edge takes the registered pdm_clk from 1 to 0.
  assign tick   = en && pdm_clk && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign strobe = tick && (dec_cnt == LOG2_DEC'(DECIMATION - 1));
  assign x_map  = sync_q[1] ? W'(1) : {W{1'b1}};

  // Half-period divider and microphone clock; disabled holds both at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous microphone data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pdm_data};
  end

  // Pipelined integrator cascade and decimation counter, advanced per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      for (int i = 0; i < CIC_ORDER; i++) integ[i] <= '0;
    end else if (!en) begin
      dec_cnt <= '0;
      for (int i = 0; i < CIC_ORDER; i++) integ[i] <= '0;
    end else if (tick) begin
      dec_cnt  <= dec_cnt + LOG2_DEC'(1);
      integ[0] <= integ[0] + x_map;
      for (int i = 1; i < CIC_ORDER; i++) integ[i] <= integ[i] + integ[i-1];
    end
  end

  // Comb chain evaluated in one cycle from the last integrator.
  always_comb begin
    logic signed [W-1:0] acc;
    acc = integ[CIC_ORDER-1];
    for (int i = 0; i < CIC_ORDER; i++) begin
      comb_in[i] = acc;
      acc        = acc - dly[i];
    end
    comb_res = acc;
  end

  assign scaled = comb_res >>> S;

`ifdef PDM_CIC_SATURATE_EN
  localparam logic signed [W-1:0] MAX_VAL = W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [W-1:0] MIN_VAL = W'(-(1 << (DATA_WIDTH - 1)));

  // Clamp to the signed PCM range so +full-scale lands on the max code.
  always_comb begin
    pcm = scaled[DATA_WIDTH-1:0];
    if (scaled > MAX_VAL)      pcm = MAX_VAL[DATA_WIDTH-1:0];
    else if (scaled < MIN_VAL) pcm = MIN_VAL[DATA_WIDTH-1:0];
  end
`else
  logic unused_scaled;
  assign unused_scaled = ^scaled;

  // Plain truncation; +full-scale wraps to the most negative code.
  always_comb begin
    pcm = scaled[DATA_WIDTH-1:0];
  end
`endif

  // Comb delay lines and PCM output register, updated on the decimation strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < CIC_ORDER; i++) dly[i] <= '0;
    end else if (!en) begin
      out_valid <= 1'b0;
      for (int i = 0; i < CIC_ORDER; i++) dly[i] <= '0;
    end else begin
      out_valid <= strobe;
      if (strobe) begin
        out_data <= pcm;
        for (int i = 0; i < CIC_ORDER; i++) dly[i] <= comb_in[i];
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters.
`timescale 1ns/1ps
module tb_pdm_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        pdm_data;
  logic        pdm_clk;
  logic [15:0] out_data;
  logic        out_valid;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit alt_mode = 1'b0;

`ifdef PDM_CIC_SATURATE_EN
  localparam logic [15:0] EXP_ONE = 16'h7FFF;
`else
  localparam logic [15:0] EXP_ONE = 16'h8000;
`endif
  localparam logic [15:0] EXP_ZERO = 16'h8000;

  pdm_cic_decimator #(
    .DATA_WIDTH(16), .CIC_ORDER(4), .DECIMATION(64), .CLK_DIV(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pdm_data(pdm_data),
    .pdm_clk(pdm_clk), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 ns past it; alternating data toggles every 4 cycles.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (alt_mode && (cyc % 4 == 0)) pdm_data = ~pdm_data;
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!out_valid && cycles < 1000);
    if (!out_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_n(input int n);
    int c;
    for (int i = 0; i < n; i++) wait_valid("wait_n", c);
  endtask

  initial begin
    int c;
    int rise1, rise2, high_cnt;
    int viol;
    logic prev;

    rst_n = 1'b0; en = 1'b0; pdm_data = 1'b0;
    #1;
    check("rst_pdm_clk",   {31'd0, pdm_clk},   32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    step(); step(); step();

    // Release with enable and constant-1 input: first pulse after 64 ticks of 4 cycles.
    rst_n = 1'b1; en = 1'b1; pdm_data = 1'b1;
    wait_valid("first", c);
    check("first_valid_cycle", c, 32'd256);
    step();
    check("valid_width", {31'd0, out_valid}, 32'd0);
    wait_valid("second", c);
    check("valid_interval", c + 1, 32'd256);

    // pdm_clk period and duty.
    rise1 = -1; rise2 = -1; high_cnt = 0; prev = pdm_clk;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pdm_clk && !prev) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      if (rise1 >= 0 && rise2 < 0 && pdm_clk) high_cnt++;
      prev = pdm_clk;
    end
    check("pdm_clk_period", rise2 - rise1, 32'd4);
    check("pdm_clk_high",   high_cnt,      32'd2);

    // Constant 1: outputs 8..10 settled.
    wait_n(5);
    for (int k = 0; k < 3; k++) begin
      wait_valid("one", c);
      check("const_one", {16'd0, out_data}, {16'd0, EXP_ONE});
    end

    // Alternating input: Nyquist tone is nulled by the CIC.
    alt_mode = 1'b1;
    wait_n(7);
    for (int k = 0; k < 3; k++) begin
      wait_valid("alt", c);
      check("alternating", {31'd0, (out_data == 16'h0000 || out_data == 16'h0001 || out_data == 16'hFFFF)}, 32'd1);
    end
    alt_mode = 1'b0;

    // Constant 0: negative full scale in both builds.
    pdm_data = 1'b0;
    wait_n(7);
    for (int k = 0; k < 3; k++) begin
      wait_valid("zero", c);
      check("const_zero", {16'd0, out_data}, {16'd0, EXP_ZERO});
    end

    // Asynchronous reset mid-frame, while pdm_clk is high.
    repeat (101) step();
    for (int i = 0; i < 4 && !pdm_clk; i++) step();
    check("pre_reset_pdm_clk_high", {31'd0, pdm_clk}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pdm_clk",   {31'd0, pdm_clk},   32'd0);
    check("arst_out_data",  {16'd0, out_data},  32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    step(); step(); step();
    pdm_data = 1'b1;
    rst_n = 1'b1;
    wait_valid("post_reset", c);
    check("post_reset_first_valid", c, 32'd256);
    wait_n(6);
    for (int k = 0; k < 3; k++) begin
      wait_valid("one_b", c);
      check("const_one_after_reset", {16'd0, out_data}, {16'd0, EXP_ONE});
    end

    // Disable for 100 cycles: clock parked, no strobes, last sample held.
    en = 1'b0;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pdm_clk !== 1'b0 || out_valid !== 1'b0) viol++;
    end
    check("disabled_quiet", viol, 32'd0);
    check("disabled_hold",  {16'd0, out_data}, {16'd0, EXP_ONE});

    en = 1'b1;
    step();
    check("reenable_clk_low",  {31'd0, pdm_clk}, 32'd0);
    step();
    check("reenable_clk_rise", {31'd0, pdm_clk}, 32'd1);
    wait_valid("reen", c);
    check("reenable_first_valid", c + 2, 32'd256);
    wait_n(6);
    for (int k = 0; k < 3; k++) begin
      wait_valid("one_c", c);
      check("const_one_after_enable", {16'd0, out_data}, {16'd0, EXP_ONE});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
